// File: rtl/alu_pkg.sv
// Shared ALU control definitions: operation codes, opcode/funct7 encodings and
// the issue FSM state type. Used by the issue block, its decoder and the ALU.
package alu_pkg;

    typedef enum logic [2:0] {
        ALU_AND  = 3'b000,
        ALU_XOR  = 3'b001,
        ALU_SLL  = 3'b010,
        ALU_ADD  = 3'b011,
        ALU_SUB  = 3'b100,
        ALU_MUL  = 3'b101,
        ALU_ADDI = 3'b110,
        ALU_SRAI = 3'b111
    } alu_op_e;

    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;

    localparam logic [6:0] F7_BASE   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    localparam logic [2:0] F3_ADD    = 3'b000;
    localparam logic [2:0] F3_SLL    = 3'b001;
    localparam logic [2:0] F3_XOR    = 3'b100;
    localparam logic [2:0] F3_SR     = 3'b101;
    localparam logic [2:0] F3_AND    = 3'b111;

    // Wide enough for the largest latency preload (MUL_LAT-1 with MUL_LAT <= 15).
    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        EXEC = 2'b01,
        HOLD = 2'b10
    } state_e;

endpackage

// File: rtl/alu_ctrl_decode.sv
// Purely combinational field decoder: {opcode, funct3, funct7} -> ALU op code,
// ALUSrc select and a legal flag for the supported subset.
module alu_ctrl_decode
    import alu_pkg::*;
(
    input  logic [6:0] opcode_i,
    input  logic [2:0] funct3_i,
    input  logic [6:0] funct7_i,
    output alu_op_e    code_o,
    output logic       alusrc_o,
    output logic       legal_o
);

    always_comb begin
        code_o   = ALU_AND;
        alusrc_o = 1'b0;
        legal_o  = 1'b0;
        if (opcode_i == OP_RTYPE) begin
            case ({funct7_i, funct3_i})
                {F7_BASE, F3_AND}:   begin code_o = ALU_AND; legal_o = 1'b1; end
                {F7_BASE, F3_XOR}:   begin code_o = ALU_XOR; legal_o = 1'b1; end
                {F7_BASE, F3_SLL}:   begin code_o = ALU_SLL; legal_o = 1'b1; end
                {F7_BASE, F3_ADD}:   begin code_o = ALU_ADD; legal_o = 1'b1; end
                {F7_ALT, F3_ADD}:    begin code_o = ALU_SUB; legal_o = 1'b1; end
                {F7_MULDIV, F3_ADD}: begin code_o = ALU_MUL; legal_o = 1'b1; end
                default: ;
            endcase
        end else if (opcode_i == OP_ITYPE) begin
            // ADDI ignores funct7 (it carries immediate bits); SRAI needs the arithmetic flag.
            if (funct3_i == F3_ADD) begin
                code_o   = ALU_ADDI;
                alusrc_o = 1'b1;
                legal_o  = 1'b1;
            end else if (funct3_i == F3_SR && funct7_i == F7_ALT) begin
                code_o   = ALU_SRAI;
                alusrc_o = 1'b1;
                legal_o  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/alu_ctrl_issue.sv
// ALU control issue block: accepts decoded fields, holds ALU op/ALUSrc for the op latency,
// then strobes result-valid to writeback. Optional counters under `ALU_CTRL_PERF_EN.
module alu_ctrl_issue
    import alu_pkg::*;
#(
    parameter int MUL_LAT = 3
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        valid_i,
    output logic        ready_o,
    input  logic [6:0]  opcode_i,
    input  logic [2:0]  funct3_i,
    input  logic [6:0]  funct7_i,
    output logic [2:0]  ALUCtrl_o,
    output logic        ALUSrc_o,
    output logic        res_valid_o,
    input  logic        res_ready_i,
    output logic        illegal_o
`ifdef ALU_CTRL_PERF_EN
    ,
    output logic [31:0] perf_ops_o,
    output logic [31:0] perf_stall_o,
    output logic [15:0] perf_illegal_o
`endif
);

    localparam logic [CNT_W-1:0] MUL_CNT = CNT_W'(MUL_LAT - 1);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    alu_op_e            code_q, code_d;
    logic               src_q, src_d;
    logic               ill_q, ill_d;
    logic               rv_q, rv_d;
    logic               rdy_q, rdy_d;

    alu_op_e            dec_code;
    logic               dec_src;
    logic               dec_legal;

    alu_ctrl_decode u_decode (
        .opcode_i (opcode_i),
        .funct3_i (funct3_i),
        .funct7_i (funct7_i),
        .code_o   (dec_code),
        .alusrc_o (dec_src),
        .legal_o  (dec_legal)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        code_d  = code_q;
        src_d   = src_q;
        ill_d   = 1'b0;
        rv_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (valid_i) begin
                    if (dec_legal) begin
                        code_d  = dec_code;
                        src_d   = dec_src;
                        cnt_d   = (dec_code == ALU_MUL) ? MUL_CNT : '0;
                        state_d = EXEC;
                    end else begin
                        ill_d = 1'b1;
                    end
                end
            end
            EXEC: begin
                if (cnt_q == '0) begin
                    state_d = HOLD;
                    rv_d    = 1'b1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            HOLD: begin
                // Leaving HOLD lands in IDLE with ready low for this edge, so no same-cycle re-accept.
                if (res_ready_i) begin
                    state_d = IDLE;
                end else begin
                    rv_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        rdy_d = (state_d == IDLE);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            code_q  <= ALU_AND;
            src_q   <= 1'b0;
            ill_q   <= 1'b0;
            rv_q    <= 1'b0;
            rdy_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            code_q  <= code_d;
            src_q   <= src_d;
            ill_q   <= ill_d;
            rv_q    <= rv_d;
            rdy_q   <= rdy_d;
        end
    end

    assign ready_o     = rdy_q;
    assign ALUCtrl_o   = code_q;
    assign ALUSrc_o    = src_q;
    assign res_valid_o = rv_q;
    assign illegal_o   = ill_q;

`ifdef ALU_CTRL_PERF_EN
    logic [31:0] perf_ops_q;
    logic [31:0] perf_stall_q;
    logic [15:0] perf_ill_q;
    logic        stall_inc;

    // Stalls: latency cycles beyond the first in EXEC, plus writeback back-pressure in HOLD.
    assign stall_inc = ((state_q == EXEC) && (cnt_q != '0)) ||
                       ((state_q == HOLD) && !res_ready_i);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            perf_ops_q   <= '0;
            perf_stall_q <= '0;
            perf_ill_q   <= '0;
        end else begin
            if (rv_q && res_ready_i) perf_ops_q <= perf_ops_q + 32'd1;
            if (stall_inc)           perf_stall_q <= perf_stall_q + 32'd1;
            if (ill_q)               perf_ill_q <= perf_ill_q + 16'd1;
        end
    end

    assign perf_ops_o     = perf_ops_q;
    assign perf_stall_o   = perf_stall_q;
    assign perf_illegal_o = perf_ill_q;
`endif

endmodule

// File: tb/tb_alu_ctrl_issue.sv
// Bench for alu_ctrl_issue: directed and randomized ops against a table-driven reference
// model; a second instance with MUL_LAT=1 covers the single-cycle MUL case.
module tb_alu_ctrl_issue;

    localparam int MUL_LAT = 3;

    typedef struct packed {
        logic [6:0] op;
        logic [2:0] f3;
        logic [6:0] f7;
        logic       f7_any;
        logic [2:0] code;
        logic       src;
    } enc_t;

    enc_t tbl [8];

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        valid = 1'b0;
    logic        res_ready = 1'b0;
    logic [6:0]  opcode = '0;
    logic [2:0]  funct3 = '0;
    logic [6:0]  funct7 = '0;

    logic        ready3, src3, rv3, ill3;
    logic [2:0]  ctrl3;

    logic        valid1 = 1'b0;
    logic        rr1 = 1'b0;
    logic        ready1, src1, rv1, ill1;
    logic [2:0]  ctrl1;

`ifdef ALU_CTRL_PERF_EN
    logic [31:0] pops3, pstall3, pops1, pstall1;
    logic [15:0] pill3, pill1;
`endif

    int n_tests = 0;
    int n_fail  = 0;
    int m_ops = 0, m_stall = 0, m_ill = 0;
    logic [2:0] last_code = 3'b000;
    logic       last_src  = 1'b0;

    always #5 clk = ~clk;

    alu_ctrl_issue #(.MUL_LAT(MUL_LAT)) u_dut3 (
        .clk_i       (clk),
        .rst_i       (rst),
        .valid_i     (valid),
        .ready_o     (ready3),
        .opcode_i    (opcode),
        .funct3_i    (funct3),
        .funct7_i    (funct7),
        .ALUCtrl_o   (ctrl3),
        .ALUSrc_o    (src3),
        .res_valid_o (rv3),
        .res_ready_i (res_ready),
        .illegal_o   (ill3)
`ifdef ALU_CTRL_PERF_EN
        ,
        .perf_ops_o     (pops3),
        .perf_stall_o   (pstall3),
        .perf_illegal_o (pill3)
`endif
    );

    alu_ctrl_issue #(.MUL_LAT(1)) u_dut1 (
        .clk_i       (clk),
        .rst_i       (rst),
        .valid_i     (valid1),
        .ready_o     (ready1),
        .opcode_i    (opcode),
        .funct3_i    (funct3),
        .funct7_i    (funct7),
        .ALUCtrl_o   (ctrl1),
        .ALUSrc_o    (src1),
        .res_valid_o (rv1),
        .res_ready_i (rr1),
        .illegal_o   (ill1)
`ifdef ALU_CTRL_PERF_EN
        ,
        .perf_ops_o     (pops1),
        .perf_stall_o   (pstall1),
        .perf_illegal_o (pill1)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic void ref_lookup(input logic [6:0] op, input logic [2:0] f3,
                                       input logic [6:0] f7, output bit legal,
                                       output logic [2:0] code, output logic src);
        legal = 1'b0;
        code  = 3'b000;
        src   = 1'b0;
        foreach (tbl[i]) begin
            if (op == tbl[i].op && f3 == tbl[i].f3 && (tbl[i].f7_any || f7 == tbl[i].f7)) begin
                legal = 1'b1;
                code  = tbl[i].code;
                src   = tbl[i].src;
            end
        end
    endfunction

`ifdef ALU_CTRL_PERF_EN
    task automatic chk_perf();
        chk("perf_ops", pops3, 32'(m_ops));
        chk("perf_stall", pstall3, 32'(m_stall));
        chk("perf_illegal", 32'(pill3), 32'(m_ill));
    endtask
`endif

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Called at a negedge with dut3 idle; ends at a negedge with dut3 idle again.
    task automatic do_op(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                         input int stall);
        bit         legal;
        logic [2:0] code;
        logic       src;
        int         lat;
        ref_lookup(op, f3, f7, legal, code, src);
        lat = (legal && code == 3'b101) ? MUL_LAT + 1 : 2;
        chk("ready_before", 32'(ready3), 32'd1);
        valid  = 1'b1;
        opcode = op;
        funct3 = f3;
        funct7 = f7;
        step();
        valid = 1'b0;
        if (!legal) begin
            chk("ill_pulse", 32'(ill3), 32'd1);
            chk("ill_ready", 32'(ready3), 32'd1);
            chk("ill_rv", 32'(rv3), 32'd0);
            m_ill++;
            step();
            chk("ill_clear", 32'(ill3), 32'd0);
            chk("ill_rv_after", 32'(rv3), 32'd0);
            chk("ill_ctrl_kept", 32'(ctrl3), 32'(last_code));
            chk("ill_src_kept", 32'(src3), 32'(last_src));
`ifdef ALU_CTRL_PERF_EN
            chk_perf();
`endif
            return;
        end
        for (int k = 1; k < lat; k++) begin
            chk("exec_rv", 32'(rv3), 32'd0);
            chk("exec_ready", 32'(ready3), 32'd0);
            chk("exec_ctrl", 32'(ctrl3), 32'(code));
            chk("exec_src", 32'(src3), 32'(src));
            chk("exec_ill", 32'(ill3), 32'd0);
            // Junk handshakes while busy must be ignored.
            valid     = 1'($urandom_range(0, 1));
            res_ready = 1'($urandom_range(0, 1));
            opcode    = 7'($urandom);
            funct3    = 3'($urandom);
            step();
        end
        valid     = 1'b0;
        res_ready = 1'b0;
        m_stall  += lat - 2;
        for (int s = 0; s < stall; s++) begin
            chk("hold_rv", 32'(rv3), 32'd1);
            chk("hold_ready", 32'(ready3), 32'd0);
            chk("hold_ctrl", 32'(ctrl3), 32'(code));
            chk("hold_src", 32'(src3), 32'(src));
            valid  = 1'($urandom_range(0, 1));
            opcode = 7'($urandom);
            step();
            chk("hold_ill", 32'(ill3), 32'd0);
            m_stall++;
        end
        valid = 1'b0;
        chk("res_valid", 32'(rv3), 32'd1);
        chk("res_ctrl", 32'(ctrl3), 32'(code));
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
        m_ops++;
        last_code = code;
        last_src  = src;
        chk("done_rv", 32'(rv3), 32'd0);
        chk("done_ready", 32'(ready3), 32'd1);
        chk("done_ctrl_kept", 32'(ctrl3), 32'(code));
`ifdef ALU_CTRL_PERF_EN
        chk_perf();
`endif
    endtask

    initial begin
        bit         legal_r;
        logic [2:0] code_r;
        logic       src_r;
        int         idx;
        logic [6:0] op_r, f7_r;
        logic [2:0] f3_r;

        tbl[0] = '{7'b0110011, 3'b111, 7'b0000000, 1'b0, 3'b000, 1'b0};
        tbl[1] = '{7'b0110011, 3'b100, 7'b0000000, 1'b0, 3'b001, 1'b0};
        tbl[2] = '{7'b0110011, 3'b001, 7'b0000000, 1'b0, 3'b010, 1'b0};
        tbl[3] = '{7'b0110011, 3'b000, 7'b0000000, 1'b0, 3'b011, 1'b0};
        tbl[4] = '{7'b0110011, 3'b000, 7'b0100000, 1'b0, 3'b100, 1'b0};
        tbl[5] = '{7'b0110011, 3'b000, 7'b0000001, 1'b0, 3'b101, 1'b0};
        tbl[6] = '{7'b0010011, 3'b000, 7'b0000000, 1'b1, 3'b110, 1'b1};
        tbl[7] = '{7'b0010011, 3'b101, 7'b0100000, 1'b0, 3'b111, 1'b1};

        // Reset values
        @(negedge clk);
        chk("rst_ctrl", 32'(ctrl3), 32'd0);
        chk("rst_src", 32'(src3), 32'd0);
        chk("rst_rv", 32'(rv3), 32'd0);
        chk("rst_ill", 32'(ill3), 32'd0);
        step();
        rst = 1'b0;
        step();
        chk("rst_ready", 32'(ready3), 32'd1);
        chk("rst_ready1", 32'(ready1), 32'd1);

        // Directed ops
        do_op(7'b0110011, 3'b000, 7'b0000000, 0);   // ADD
        do_op(7'b0110011, 3'b000, 7'b0000001, 0);   // MUL
        do_op(7'b0010011, 3'b101, 7'b0100000, 1);   // SRAI
        do_op(7'b0010011, 3'b000, 7'b1111111, 0);   // ADDI, f7 ignored
        do_op(7'b0110011, 3'b010, 7'b0000000, 0);   // illegal
        do_op(7'b0110011, 3'b000, 7'b0100000, 5);   // SUB with back-pressure
        do_op(7'b0010011, 3'b101, 7'b0000000, 0);   // SRAI without flag: illegal
        do_op(7'b0110011, 3'b111, 7'b0000000, 2);   // AND
        do_op(7'b0110011, 3'b000, 7'b0000001, 3);   // MUL with back-pressure

        // Randomized ops
        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 9) < 7) begin
                idx  = $urandom_range(0, 7);
                op_r = tbl[idx].op;
                f3_r = tbl[idx].f3;
                f7_r = tbl[idx].f7_any ? 7'($urandom) : tbl[idx].f7;
            end else begin
                op_r = ($urandom_range(0, 1) == 1) ? 7'b0110011 : 7'($urandom);
                f3_r = 3'($urandom);
                case ($urandom_range(0, 3))
                    0:       f7_r = 7'b0000000;
                    1:       f7_r = 7'b0100000;
                    2:       f7_r = 7'b0000001;
                    default: f7_r = 7'($urandom);
                endcase
            end
            do_op(op_r, f3_r, f7_r, int'($urandom_range(0, 3)));
        end

        // MUL_LAT=1 instance: MUL completes like a single-cycle op
        ref_lookup(7'b0110011, 3'b000, 7'b0000001, legal_r, code_r, src_r);
        opcode = 7'b0110011;
        funct3 = 3'b000;
        funct7 = 7'b0000001;
        valid1 = 1'b1;
        step();
        valid1 = 1'b0;
        chk("m1_exec_rv", 32'(rv1), 32'd0);
        chk("m1_exec_ready", 32'(ready1), 32'd0);
        step();
        chk("m1_rv", 32'(rv1), 32'd1);
        chk("m1_ctrl", 32'(ctrl1), 32'(code_r));
        rr1 = 1'b1;
        step();
        rr1 = 1'b0;
        chk("m1_done_rv", 32'(rv1), 32'd0);
        chk("m1_done_ready", 32'(ready1), 32'd1);

        // Reset one cycle into a MUL aborts it
        opcode = 7'b0110011;
        funct3 = 3'b000;
        funct7 = 7'b0000001;
        valid  = 1'b1;
        step();
        valid = 1'b0;
        chk("pre_rst_ctrl", 32'(ctrl3), 32'd5);
        rst = 1'b1;
        #1;
        chk("arst_ctrl", 32'(ctrl3), 32'd0);
        chk("arst_src", 32'(src3), 32'd0);
        chk("arst_rv", 32'(rv3), 32'd0);
        chk("arst_ill", 32'(ill3), 32'd0);
        chk("arst_ready", 32'(ready3), 32'd1);
        step();
        rst = 1'b0;
        m_ops = 0;
        m_stall = 0;
        m_ill = 0;
        last_code = 3'b000;
        last_src = 1'b0;
        res_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            step();
            chk("post_rst_rv", 32'(rv3), 32'd0);
        end
        res_ready = 1'b0;

        // Counters after reset: 3 ADD + 1 illegal
        do_op(7'b0110011, 3'b000, 7'b0000000, 0);
        do_op(7'b0110011, 3'b000, 7'b0000000, 1);
        do_op(7'b0110011, 3'b011, 7'b0000000, 0);
        do_op(7'b0110011, 3'b000, 7'b0000000, 0);
`ifdef ALU_CTRL_PERF_EN
        chk("perf_ops_final", pops3, 32'd3);
        chk("perf_ill_final", 32'(pill3), 32'd1);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_ctrl_issue.md
Name: alu_ctrl_issue

Overview:
- Initiator side of the ALU control interface.
- Accepts decoded instruction fields (opcode, funct3, funct7) over a valid/ready handshake and maps them to the 3-bit ALU operation code and the ALUSrc select.
- Holds both stable for the operation's latency: 1 cycle for all ops, MUL_LAT cycles for MUL.
- Then presents the result-valid strobe to writeback over a second valid/ready handshake.
- Sits between decode and the combinational ALU in the CPU datapath.

Parameters:
- MUL_LAT, 3, cycles ALUCtrl_o is held for MUL before the result is valid (legal range 1..15).

Ports:
- clk_i  input  1  clock, rising edge.
- rst_i  input  1  reset, asynchronous, active-high.
- valid_i  input  1  instruction fields valid.
- ready_o  output  1  block can accept an instruction.
- opcode_i  input  7  instruction opcode.
- funct3_i  input  3  funct3.
- funct7_i  input  7  funct7.
- ALUCtrl_o  output  3  operation code to the ALU.
- ALUSrc_o  output  1  1 = second operand from immediate.
- res_valid_o  output  1  ALU result valid for writeback.
- res_ready_i  input  1  writeback accepts result.
- illegal_o  output  1  one-cycle pulse on an unsupported encoding.

Behaviour:
- Operation codes (fixed): AND 000, XOR 001, SLL 010, ADD 011, SUB 100, MUL 101, ADDI 110, SRAI 111.
- Decode, opcode 0110011:
  - f3=111, f7=0000000 -> AND.
  - f3=100, f7=0000000 -> XOR.
  - f3=001, f7=0000000 -> SLL.
  - f3=000, f7=0000000 -> ADD.
  - f3=000, f7=0100000 -> SUB.
  - f3=000, f7=0000001 -> MUL.
- Decode, opcode 0010011:
  - f3=000 (f7 ignored) -> ADDI.
  - f3=101, f7=0100000 -> SRAI.
  - ALUSrc_o=1 for both.
- Anything else is illegal.
- States:
  - IDLE:
    - ready_o=1.
    - On valid_i & legal: latch code and ALUSrc; load counter with MUL_LAT-1 for MUL, else 0; go to EXEC.
    - On valid_i & illegal: pulse illegal_o next cycle and stay in IDLE. Nothing is issued.
  - EXEC:
    - ready_o=0.
    - ALUCtrl_o and ALUSrc_o held from the latched values.
    - Counter decrements each cycle.
    - When the counter is 0 at a clock edge, go to HOLD.
  - HOLD:
    - res_valid_o=1; ALUCtrl_o and ALUSrc_o still held.
    - On res_ready_i go to IDLE. ready_o goes to 1 the following cycle; no same-cycle re-accept.
- Latency, valid_i accept to res_valid_o:
  - Non-MUL: 2 cycles (accept edge, EXEC edge).
  - MUL: MUL_LAT+1 cycles.
- With MUL_LAT=1, MUL behaves exactly like a single-cycle op.
- Back-pressure: res_ready_i low holds HOLD indefinitely; all outputs stay stable.
- res_ready_i asserted outside HOLD is ignored.
- Reset values (asynchronous): state IDLE, ALUCtrl_o=000, ALUSrc_o=0, res_valid_o=0, illegal_o=0, counter=0. ready_o=1 once reset deasserts.
- Reset asserted mid-EXEC or mid-HOLD aborts the op. No result strobe follows.
- Outputs are registered. ALUCtrl_o keeps its last value in IDLE; it is not cleared.

Optional Feature:
- Macro: ALU_CTRL_PERF_EN.
- When defined, adds ports:
  - perf_ops_o, output, 32 bits: count of res_valid_o & res_ready_i handshakes.
  - perf_stall_o, output, 32 bits: count of cycles in EXEC with counter>0 plus cycles in HOLD with res_ready_i=0.
  - perf_illegal_o, output, 16 bits: count of illegal pulses.
- All three counters are cleared by rst_i and wrap on overflow.
- When undefined, the ports and logic are absent and behaviour is otherwise identical.

Decomposition:
- Shared package alu_pkg holds:
  - The 3-bit operation-code constants.
  - Opcode constants OP_RTYPE=0110011 and OP_ITYPE=0010011.
  - funct7 constants F7_BASE, F7_ALT, F7_MULDIV.
  - State enum IDLE/EXEC/HOLD.
- One natural sub-module: alu_ctrl_decode. It is purely combinational: fields -> {code, alusrc, legal}. The ALU itself uses the same package constants.

Test Plan:
- Reset then ADD: opcode 0110011, f3 000, f7 0000000, valid_i for 1 cycle -> ALUCtrl_o=011, ALUSrc_o=0, res_valid_o high 2 cycles after accept, res_ready_i=1 -> IDLE, ready_o=1 next cycle.
- MUL with MUL_LAT=3: f7 0000001 -> ALUCtrl_o=101 held, res_valid_o high exactly 4 cycles after accept; sweep MUL_LAT=1 -> 2 cycles.
- SRAI: opcode 0010011, f3 101, f7 0100000 -> 111, ALUSrc_o=1. ADDI with f7 1111111 -> 110, ALUSrc_o=1.
- Illegal: opcode 0110011, f3 010 -> illegal_o 1-cycle pulse, ready_o stays 1, res_valid_o never asserts.
- Back-pressure: SUB (f7 0100000), res_ready_i low 5 cycles -> res_valid_o=1, ALUCtrl_o=100 stable throughout, ready_o=0, valid_i ignored; release -> single handshake.
- Reset mid-MUL (1 cycle after accept) -> all outputs at reset values immediately, no res_valid_o; with ALU_CTRL_PERF_EN, 3 ADD ops + 1 illegal -> perf_ops_o=3, perf_illegal_o=1.
